// File: rtl/frame_sync_deserializer.sv
// Frame-locked serial deserializer: hunts for preamble/postamble framing,
// flywheels across isolated bad frames, buffers words in a show-ahead FIFO.
// Ports: clock, reset_n (async low), serin -> data/valid/ready FIFO head,
//        locked, frame_err/overflow pulses, saturating err_count.
module frame_sync_deserializer #(
    parameter int              DATA_W     = 8,
    parameter int              PRE_W      = 5,
    parameter int              POST_W     = 5,
    parameter logic [PRE_W-1:0]  PREAMBLE  = 5'b10001,
    parameter logic [POST_W-1:0] POSTAMBLE = 5'b01110,
    parameter int              MISS_LIMIT = 3,
    parameter int              DEPTH      = 4,
    parameter int              ERR_W      = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              serin,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              locked,
    output logic              frame_err,
    output logic              overflow,
    output logic [ERR_W-1:0]  err_count
);

    localparam int FRAME_W = PRE_W + DATA_W + POST_W;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W - 1);
    localparam logic [3:0]       MISS_MAX = 4'(MISS_LIMIT);
    localparam logic [AW:0]      OCC_FULL = (AW+1)'(DEPTH);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t             state, state_nxt;
    logic [FRAME_W-1:0] win;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [3:0]         miss, miss_nxt;
    logic               match, push, miss_evt;
    logic [DATA_W-1:0]  word;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        occ;
    logic               full, pop, wr_en;

    assign match = (win[PRE_W-1:0] == PREAMBLE) &&
                   (win[FRAME_W-1 -: POST_W] == POSTAMBLE);
    assign word  = win[PRE_W +: DATA_W];

    // Oldest bit sits at win[0]; new bits enter at the MSB.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) win <= '0;
        else          win <= {serin, win[FRAME_W-1:1]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= HUNT;
            cnt   <= '0;
            miss  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            miss  <= miss_nxt;
        end
    end

    // Only the boundary cycle (cnt == 0) is looked at once locked, so
    // pattern look-alikes inside the data never cause a resync.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        miss_nxt  = miss;
        push      = 1'b0;
        miss_evt  = 1'b0;
        unique case (state)
            HUNT: begin
                if (match) begin
                    push      = 1'b1;
                    state_nxt = LOCKED;
                    cnt_nxt   = CNT_MAX;
                    miss_nxt  = '0;
                end
            end
            LOCKED: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    cnt_nxt = CNT_MAX;
                    if (match) begin
                        push     = 1'b1;
                        miss_nxt = '0;
                    end else begin
                        miss_evt = 1'b1;
                        if (miss + 4'd1 == MISS_MAX) begin
                            state_nxt = HUNT;
                            miss_nxt  = '0;
                        end else begin
                            miss_nxt = miss + 4'd1;
                        end
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    assign locked = (state == LOCKED);

    assign full  = (occ == OCC_FULL);
    assign valid = (occ != '0);
    assign pop   = valid && ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign wr_en = push && (!full || pop);
    assign data  = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= word;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            frame_err <= miss_evt;
            overflow  <= push && full && !pop;
            if (miss_evt && (err_count != '1))
                err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: doc/frame_sync_deserializer.md
# frame_sync_deserializer

Parametrised, flywheel-locked successor to the team's fixed 8-bit framed deserializer. It recovers framed words from a single-bit serial stream, clocked one bit per `clock` edge. Each frame has the layout preamble, data (LSB first), postamble. After the first match the block locks to the frame boundary and tolerates isolated corrupted frames. Recovered words are buffered in a small FIFO with a valid/ready interface for the downstream consumer.

## Interface
- `DATA_W`, default 8: data bits per frame.
- `PRE_W`, default 5: preamble length.
- `POST_W`, default 5: postamble length.
- `PREAMBLE`, default 5'b10001: preamble pattern. Bit 0 is transmitted first.
- `POSTAMBLE`, default 5'b01110: postamble pattern. Bit 0 is transmitted first.
- `MISS_LIMIT`, default 3: consecutive boundary misses that cause loss of lock. Legal range is 1..15.
- `DEPTH`, default 4: FIFO depth in words. Must be a power of two, at least 2.
- `ERR_W`, default 8: width of the error counter.
- Derived: `FRAME_W` = PRE_W + DATA_W + POST_W (18 at defaults).

Ports:
- `clock` in 1: bit clock. Single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `serin` in 1: serial data, sampled on the rising edge of `clock`.
- `data` out DATA_W: FIFO head word. Meaningful only while `valid` is 1.
- `valid` out 1: FIFO not empty.
- `ready` in 1: consumer accepts the head word. A pop occurs when `valid` and `ready` are both 1.
- `locked` out 1: 1 while the state machine is in LOCKED.
- `frame_err` out 1: one-cycle pulse on each boundary miss while locked.
- `overflow` out 1: one-cycle pulse when a recovered word is dropped because the FIFO is full.
- `err_count` out ERR_W: count of boundary misses. Saturating.

## Operation
- **Shift window.** `win[FRAME_W-1:0]` shifts right on every edge; `serin` enters at the MSB. As a result, `win[0]` holds the oldest bit.
- **Match condition** (combinational, evaluated on the registered window):
  - `win[PRE_W-1:0]` == PREAMBLE, and
  - `win[FRAME_W-1:FRAME_W-POST_W]` == POSTAMBLE.
- **Word extraction.** The recovered word is `win[PRE_W+DATA_W-1:PRE_W]`.
- **HUNT state** (reset state):
  - The match condition is checked every cycle.
  - On a match: push the word, enter LOCKED, load the bit counter `cnt` with FRAME_W-1, and clear the miss counter.
- **LOCKED state:**
  - `cnt` decrements on every edge. The frame boundary is the cycle in which `cnt` == 0.
  - Matches that occur off the boundary are ignored. This rejects false syncs inside data.
  - Boundary with a match: push the word, clear the miss counter, reload `cnt` with FRAME_W-1.
  - Boundary without a match: no push; pulse `frame_err`; increment `err_count` (saturating at all ones); increment the miss counter.
    - If the miss counter reaches MISS_LIMIT, go to HUNT and clear the miss counter.
    - Otherwise reload `cnt` (flywheel) and stay in LOCKED.
  - Boundary push or miss, whichever applies, happens at the same edge as the `cnt` reload.
- **FIFO:**
  - Show-ahead: `data` presents the head word whenever `valid` is 1.
  - Pop: when `valid` && `ready`.
  - Push while full: the word is dropped and `overflow` pulses. The exception is a pop in the same cycle, in which case both operations succeed and the occupancy is unchanged.
  - Push and pop on a non-full, non-empty FIFO: both succeed; occupancy is unchanged.
  - Pointers wrap modulo DEPTH. Use an occupancy counter of width log2(DEPTH)+1.
- **Lock loss** does not flush the FIFO. Words already buffered remain available to the consumer.

## Timing
- **Reset values** (while `reset_n` is low, asynchronously):
  - `win`, `cnt`, miss counter, FIFO pointers and occupancy: 0.
  - State: HUNT.
  - Outputs: `valid` 0, `data` 0, `locked` 0, `frame_err` 0, `overflow` 0, `err_count` 0.
- **Reset mid-frame or mid-lock** discards the partial window and all buffered words.
- **Latency.** Let edge E be the edge that samples the last postamble bit.
  - The push happens at edge E+1.
  - `valid` (if the FIFO was empty) and `data` update after E+1.
  - `locked` rises after E+1 for the first frame.
- **Back-to-back frames.** Successive pushes are exactly FRAME_W edges apart.
- **Pulse timing.**
  - `frame_err` is high for exactly the one cycle following the boundary edge.
  - `overflow` is high for exactly the one cycle following the dropped-push edge.
- **Lock drop.** `locked` falls after the edge of the MISS_LIMIT-th consecutive miss.
  - Hunting resumes on the very next cycle's window.
  - A match evaluated in that same boundary cycle does not count, because the boundary path takes priority.
- **Consumer behaviour.** `ready` may be held permanently high. There is no combinational path from `ready` to `valid`.

## Test plan
- **Single frame, defaults.**
  - Stimulus: serial 1,0,0,0,1 | 1,0,1,0,0,1,0,1 | 0,1,1,1,0, with `ready`=1.
  - Required response: `data`=8'hA5 with `valid` high for 1 cycle after edge E+1; `locked` rises at the same time.
- **Continuous stream.**
  - Stimulus: 10 back-to-back frames 0x00..0x09, `ready`=1.
  - Required response: 10 pops in order, 18 cycles apart; `err_count`=0.
- **Flywheel.**
  - Stimulus: while locked, corrupt the postamble of frame 3 only.
  - Required response: one `frame_err` pulse; `err_count`=1; `locked` stays high; frame 4 is recovered with no gap in the 18-cycle cadence.
- **Lock loss and reacquire.**
  - Stimulus: 3 consecutive corrupted frames, then 2 frames offset by 7 bits.
  - Required response: `locked` low after the 3rd miss; `err_count`=3; the new frames are recovered at the new phase.
- **Off-boundary rejection.**
  - Stimulus: while locked, data bytes chosen so a full preamble/data/postamble pattern appears inside the stream off the boundary.
  - Required response: no extra push.
- **Backpressure.**
  - Stimulus: `ready`=0, 6 frames with DEPTH=4.
  - Required response: 4 words buffered; `overflow` pulses twice.
  - Follow-up: raise `ready` on the cycle of a 7th push while full. Required response: the pop and the push both succeed.
- **Async reset.**
  - Stimulus: assert `reset_n` low mid-frame while the FIFO holds 2 words.
  - Required response: all outputs 0 immediately; the next full frame is recovered normally.
